// File: rtl/fetch_queue_unit.sv
// Fetch stage with a small {PC, instruction} queue drained by decode over valid/ready.
// Optional statistics counters are enabled by defining FETCH_QUEUE_STATS_EN.
module fetch_queue_unit #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned INSTR_W  = 32,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned PC_STEP  = 4,
   parameter int unsigned RESET_PC = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     BranchTakenE,
   input  logic [WIDTH-1:0]         ALUResultE,
   input  logic                     PCSrcW,
   input  logic [WIDTH-1:0]         ResultW,
   output logic [WIDTH-1:0]         imem_addr,
   input  logic [INSTR_W-1:0]       imem_rdata,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [INSTR_W-1:0]       out_instr,
   output logic [WIDTH-1:0]         out_pc,
   output logic [WIDTH-1:0]         out_pc_plus,
   output logic [$clog2(DEPTH):0]   occupancy
`ifdef FETCH_QUEUE_STATS_EN
   ,
   output logic [31:0]              stat_fetched,
   output logic [15:0]              stat_flushes,
   output logic [31:0]              stat_full_stall
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   typedef struct packed {
      logic [WIDTH-1:0]   pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   entry_t             mem [DEPTH];
   entry_t             head_entry;
   logic [WIDTH-1:0]   pc;
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;
   logic [OCC_W-1:0]   occ;
   logic               pop;
   logic               push;
   logic               redirect;
   logic               full;

   // Handshake and enqueue decisions for this cycle
   always_comb begin
      full       = (occ == OCC_W'(DEPTH));
      redirect   = BranchTakenE | PCSrcW;
      pop        = (occ != '0) & out_ready;
      push       = ~redirect & (~full | pop);
      head_entry = mem[head];
   end

   assign imem_addr   = pc;
   assign out_valid   = (occ != '0);
   assign out_instr   = head_entry.instr;
   assign out_pc      = head_entry.pc;
   assign out_pc_plus = head_entry.pc + WIDTH'(PC_STEP);
   assign occupancy   = occ;

   // Storage is not reset; validity is tracked by occ alone
   always_ff @(posedge clk) begin
      if (push) begin
         mem[tail] <= '{pc: pc, instr: imem_rdata};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc   <= WIDTH'(RESET_PC);
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else if (redirect) begin
         pc   <= BranchTakenE ? ALUResultE : ResultW;
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         if (push) begin
            pc   <= pc + WIDTH'(PC_STEP);
            tail <= tail + PTR_W'(1);
         end
         if (pop) begin
            head <= head + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   occ <= occ + OCC_W'(1);
            2'b01:   occ <= occ - OCC_W'(1);
            default: occ <= occ;
         endcase
      end
   end

`ifdef FETCH_QUEUE_STATS_EN
   // Saturating event counters
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_fetched    <= '0;
         stat_flushes    <= '0;
         stat_full_stall <= '0;
      end else begin
         if (push && (stat_fetched != '1)) begin
            stat_fetched <= stat_fetched + 32'd1;
         end
         if (redirect && (stat_flushes != '1)) begin
            stat_flushes <= stat_flushes + 16'd1;
         end
         if (full && !pop && (stat_full_stall != '1)) begin
            stat_full_stall <= stat_full_stall + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed self-checking bench for fetch_queue_unit (default parameters).
module tb_fetch_queue_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        BranchTakenE;
   logic [7:0]  ALUResultE;
   logic        PCSrcW;
   logic [7:0]  ResultW;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [7:0]  out_pc;
   logic [7:0]  out_pc_plus;
   logic [2:0]  occupancy;
`ifdef FETCH_QUEUE_STATS_EN
   logic [31:0] stat_fetched;
   logic [15:0] stat_flushes;
   logic [31:0] stat_full_stall;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Address-tagged instruction memory
   assign imem_rdata = {24'hABCDEF, imem_addr};

   function automatic logic [31:0] tag(input logic [7:0] a);
      return {24'hABCDEF, a};
   endfunction

   fetch_queue_unit dut (
      .clk(clk), .reset(reset),
      .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE),
      .PCSrcW(PCSrcW), .ResultW(ResultW),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .out_pc_plus(out_pc_plus),
      .occupancy(occupancy)
`ifdef FETCH_QUEUE_STATS_EN
      , .stat_fetched(stat_fetched), .stat_flushes(stat_flushes),
      .stat_full_stall(stat_full_stall)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1; out_ready = 1'b0;
      BranchTakenE = 1'b0; ALUResultE = '0; PCSrcW = 1'b0; ResultW = '0;
      step(); step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; out_ready = 1'b0;
      BranchTakenE = 1'b0; ALUResultE = '0; PCSrcW = 1'b0; ResultW = '0;
      step(); step();
      checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h expected 00", imem_addr); end
      reset = 1'b0;
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, out_valid); end
         checks++; if (out_pc !== 8'(4*i)) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, out_pc, 8'(4*i)); end
         checks++; if (out_pc_plus !== 8'(4*i+4)) begin errors++; $display("FAIL stream_pc_plus[%0d]: got %h expected %h", i, out_pc_plus, 8'(4*i+4)); end
         checks++; if (out_instr !== tag(8'(4*i))) begin errors++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, out_instr, tag(8'(4*i))); end
         checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL stream_occ[%0d]: got %0d expected 1", i, occupancy); end
      end
   endtask

   task automatic test_stall();
      apply_reset();
      repeat (10) step();
      checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL stall_occ: got %0d expected 4", occupancy); end
      checks++; if (imem_addr !== 8'h10) begin errors++; $display("FAIL stall_pc: got %h expected 10", imem_addr); end
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (out_pc !== 8'(4*i) || out_valid !== 1'b1) begin errors++; $display("FAIL drain_pc[%0d]: got %h/%b expected %h/1", i, out_pc, out_valid, 8'(4*i)); end
         checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL drain_occ[%0d]: got %0d expected 4", i, occupancy); end
         step();
      end
      out_ready = 1'b0;
   endtask

   task automatic test_full_single_pop();
      apply_reset();
      repeat (6) step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL fullpop_occ: got %0d expected 4", occupancy); end
      checks++; if (imem_addr !== 8'h14) begin errors++; $display("FAIL fullpop_pc: got %h expected 14", imem_addr); end
      checks++; if (out_pc !== 8'h04) begin errors++; $display("FAIL fullpop_head: got %h expected 04", out_pc); end
      step();
      checks++; if (imem_addr !== 8'h14) begin errors++; $display("FAIL fullhold_pc: got %h expected 14", imem_addr); end
   endtask

   task automatic test_redirect();
      // Queue is full from the previous test
      BranchTakenE = 1'b1; ALUResultE = 8'h40; PCSrcW = 1'b1; ResultW = 8'h80;
      step();
      BranchTakenE = 1'b0; PCSrcW = 1'b0;
      checks++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got occ %0d valid %b expected 0/0", occupancy, out_valid); end
      checks++; if (imem_addr !== 8'h40) begin errors++; $display("FAIL redir_prio: got %h expected 40", imem_addr); end
      step();
      checks++; if (out_valid !== 1'b1 || out_pc !== 8'h40) begin errors++; $display("FAIL redir_head: got %h/%b expected 40/1", out_pc, out_valid); end
      checks++; if (out_instr !== tag(8'h40)) begin errors++; $display("FAIL redir_instr: got %h expected %h", out_instr, tag(8'h40)); end
      PCSrcW = 1'b1; ResultW = 8'h80;
      step();
      PCSrcW = 1'b0;
      checks++; if (imem_addr !== 8'h80 || occupancy !== 3'd0) begin errors++; $display("FAIL wb_redir: got %h/%0d expected 80/0", imem_addr, occupancy); end
   endtask

   task automatic test_wrap();
      out_ready = 1'b0;
      BranchTakenE = 1'b1; ALUResultE = 8'hFC;
      step();
      BranchTakenE = 1'b0;
      step();
      checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL wrap_addr: got %h expected 00", imem_addr); end
      step();
      checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL wrap_occ: got %0d expected 2", occupancy); end
      checks++; if (out_pc !== 8'hFC || out_pc_plus !== 8'h00) begin errors++; $display("FAIL wrap_head0: got %h/%h expected FC/00", out_pc, out_pc_plus); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++; if (out_pc !== 8'h00 || out_pc_plus !== 8'h04) begin errors++; $display("FAIL wrap_head1: got %h/%h expected 00/04", out_pc, out_pc_plus); end
      checks++; if (out_instr !== tag(8'h00)) begin errors++; $display("FAIL wrap_instr: got %h expected %h", out_instr, tag(8'h00)); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      repeat (3) step();
      checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL mid_fill: got %0d expected 3", occupancy); end
      reset = 1'b1; BranchTakenE = 1'b1; ALUResultE = 8'h40; out_ready = 1'b1;
      step();
      checks++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_q: got %0d/%b expected 0/0", occupancy, out_valid); end
      checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL mid_reset_pc: got %h expected 00", imem_addr); end
`ifdef FETCH_QUEUE_STATS_EN
      checks++; if (stat_fetched !== 32'd0 || stat_flushes !== 16'd0 || stat_full_stall !== 32'd0) begin errors++; $display("FAIL mid_reset_stats: got %0d/%0d/%0d expected 0/0/0", stat_fetched, stat_flushes, stat_full_stall); end
`endif
      reset = 1'b0; BranchTakenE = 1'b0; out_ready = 1'b0;
      step();
      checks++; if (occupancy !== 3'd1 || out_pc !== 8'h00) begin errors++; $display("FAIL post_reset: got %0d/%h expected 1/00", occupancy, out_pc); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_full_single_pop();
      test_redirect();
      test_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
